// File: rtl/any1_memseq.sv
// any1_memseq: element sequencer for ANY-1 strided, indexed and vector
// loads/stores. Walks element indices 0..VL-1, feeds each one to the address
// generator, and issues one req/ack memory transaction per enabled element.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high, step forced to 0
// STEP   | present elem on step; skip it in one cycle if its mask bit is 0
// CAPT   | address generator registers ea for the current step
// ISSUE  | mem_req held with latched address until mem_ack
// DONE   | one-cycle done pulse, err valid alongside
module any1_memseq #(
    parameter  int AWID  = 32,
    parameter  int MAXVL = 64,
    localparam int SW    = $clog2(MAXVL),
    localparam int VW    = SW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_store_i,
    input  logic [VW-1:0]    cmd_vl_i,
    input  logic [MAXVL-1:0] cmd_mask_i,
    output logic [SW-1:0]    step_o,
    input  logic [AWID-1:0]  ea_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AWID-1:0]  mem_adr_o,
    output logic [SW-1:0]    mem_elem_o,
    input  logic             mem_ack_i,
    input  logic             mem_err_i,
    output logic             wb_v_o,
    output logic [SW-1:0]    wb_elem_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_CAPT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [VW-1:0]    elem_q;
    logic [VW-1:0]    vl_q;
    logic [MAXVL-1:0] mask_q;
    logic             store_q;
    logic             err_q;
    logic [AWID-1:0]  adr_q;

    logic accept;
    logic advance;
    logic abort;
    logic last;

    // elem is one bit wider than step so that vl=MAXVL terminates without wrap
    assign last = ((elem_q + VW'(1)) == vl_q);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode plus the datapath strobes that go with each transition
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = (cmd_vl_i == '0) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (!mask_q[elem_q[SW-1:0]]) begin
                    advance = 1'b1;
                    state_d = last ? S_DONE : S_STEP;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: state_d = S_ISSUE;
            S_ISSUE: begin
                if (mem_ack_i) begin
                    if (mem_err_i) begin
                        abort   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = last ? S_DONE : S_STEP;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, element counter, error flag and request address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elem_q  <= '0;
            vl_q    <= '0;
            mask_q  <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
        end else begin
            if (accept) begin
                store_q <= cmd_store_i;
                vl_q    <= cmd_vl_i;
                mask_q  <= cmd_mask_i;
                elem_q  <= '0;
                err_q   <= 1'b0;
            end
            if (advance) elem_q <= elem_q + VW'(1);
            if (abort)   err_q  <= 1'b1;
            // ea already reflects the current step here, so this edge is ISSUE entry
            if (state_q == S_CAPT) adr_q <= ea_i;
        end
    end

    // Outputs decoded from registered state; only wb_v looks at mem_ack
    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        mem_req_o   = (state_q == S_ISSUE);
        step_o      = (state_q == S_IDLE) ? '0 : elem_q[SW-1:0];
        mem_we_o    = store_q;
        mem_adr_o   = adr_q;
        mem_elem_o  = elem_q[SW-1:0];
        wb_elem_o   = elem_q[SW-1:0];
        wb_v_o      = (state_q == S_ISSUE) & mem_ack_i & ~mem_err_i & ~store_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_any1_memseq.sv
// Bench for any1_memseq: directed commands, a stride-8 address generator
// model, a configurable ack responder and a scoreboard monitor.
module tb_any1_memseq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_store = 1'b0;
    logic [6:0]  cmd_vl = '0;
    logic [63:0] cmd_mask = '0;
    logic [5:0]  step;
    logic [31:0] ea = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [5:0]  mem_elem;
    logic        mem_ack = 1'b0;
    logic        mem_err = 1'b0;
    logic        wb_v;
    logic [5:0]  wb_elem;
    logic        busy;
    logic        done;
    logic        err;

    any1_memseq #(.AWID(32), .MAXVL(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_store_i(cmd_store), .cmd_vl_i(cmd_vl), .cmd_mask_i(cmd_mask),
        .step_o(step), .ea_i(ea),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_adr_o(mem_adr),
        .mem_elem_o(mem_elem), .mem_ack_i(mem_ack), .mem_err_i(mem_err),
        .wb_v_o(wb_v), .wb_elem_o(wb_elem),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered stride-8 address generator from base 0x100
    always @(posedge clk) ea <= 32'h100 + 32'(step) * 32'd8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [5:0]  elem;
    } req_t;

    req_t       exp_req[$];
    logic [5:0] exp_wb[$];
    logic       exp_done[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Responder: ack after ack_delay wait cycles; noise on mem_err while waiting
    int ack_delay = 0;
    int err_elem  = -1;
    int wcnt      = 0;
    always @(negedge clk) begin
        if (mem_req && !mem_ack) begin
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                mem_err = (int'(mem_elem) == err_elem);
                wcnt    = 0;
            end else begin
                mem_err = 1'b1;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mem_err = 1'b0;
            wcnt    = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents req, wb_v or done
    bit   req_seen = 0;
    req_t cur_req;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            req_seen = 0;
        end else begin
            if (mem_req) begin
                if (!req_seen) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: elem %0d adr %0h", mem_elem, mem_adr);
                        cur_req.adr = mem_adr; cur_req.we = mem_we; cur_req.elem = mem_elem;
                    end else begin
                        cur_req = exp_req.pop_front();
                        chk("req_adr", 64'(mem_adr), 64'(cur_req.adr));
                        chk("req_we", 64'(mem_we), 64'(cur_req.we));
                        chk("req_elem", 64'(mem_elem), 64'(cur_req.elem));
                        chk("req_step", 64'(step), 64'(cur_req.elem));
                    end
                    req_seen = 1;
                end else begin
                    chk("hold_adr", 64'(mem_adr), 64'(cur_req.adr));
                    chk("hold_elem", 64'(mem_elem), 64'(cur_req.elem));
                    chk("hold_we", 64'(mem_we), 64'(cur_req.we));
                end
            end else begin
                req_seen = 0;
            end
            if (wb_v) begin
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: elem %0d", wb_elem);
                end else begin
                    chk("wb_elem", 64'(wb_elem), 64'(exp_wb.pop_front()));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: err %0d", err);
                end else begin
                    chk("done_err", 64'(err), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic push_req(input logic [31:0] adr, input logic we, input logic [5:0] elem);
        req_t r;
        r.adr = adr; r.we = we; r.elem = elem;
        exp_req.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_step"}, 64'(step), 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_adr"}, 64'(mem_adr), 64'd0);
        chk({tag, "_mem_elem"}, 64'(mem_elem), 64'd0);
        chk({tag, "_wb_v"}, 64'(wb_v), 64'd0);
        chk({tag, "_wb_elem"}, 64'(wb_elem), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // Issue one command, wait (bounded) for done, check latency and ready return.
    // With pulse set, cmd_valid is re-offered while the DUT is busy.
    task automatic run_cmd(input logic st, input logic [6:0] vl, input logic [63:0] mask,
                           input int exp_cycles, input bit pulse);
        int start;
        bit seen;
        @(negedge clk); #3;
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_store = st; cmd_vl = vl; cmd_mask = mask;
        start = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_store = 1'b0; cmd_vl = '0; cmd_mask = '0;
        seen = 0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk); #3;
            if (pulse && (cyc - start) >= 5 && (cyc - start) < 9) begin
                chk("ready_while_busy", 64'(cmd_ready), 64'd0);
                cmd_valid = 1'b1; cmd_store = 1'b1; cmd_vl = 7'd1; cmd_mask = '1;
            end else begin
                cmd_valid = 1'b0; cmd_store = 1'b0; cmd_vl = '0; cmd_mask = '0;
            end
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 2000 cycles (vl %0d)", vl);
        end else begin
            chk("accept_to_done", 64'(cyc - start), 64'(exp_cycles));
        end
        @(negedge clk); #3;
        chk("ready_after_done", 64'(cmd_ready), 64'd1);
        chk("done_single_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Load vl=4, all enabled, zero-wait ack
        push_req(32'h100, 1'b0, 6'd0); push_req(32'h108, 1'b0, 6'd1);
        push_req(32'h110, 1'b0, 6'd2); push_req(32'h118, 1'b0, 6'd3);
        exp_wb.push_back(6'd0); exp_wb.push_back(6'd1);
        exp_wb.push_back(6'd2); exp_wb.push_back(6'd3);
        exp_done.push_back(1'b0);
        run_cmd(1'b0, 7'd4, 64'hF, 13, 0);

        // Store vl=3, mask 0b101: element 1 skipped in one cycle
        push_req(32'h100, 1'b1, 6'd0); push_req(32'h110, 1'b1, 6'd2);
        exp_done.push_back(1'b0);
        run_cmd(1'b1, 7'd3, 64'h5, 8, 0);

        // vl=0
        exp_done.push_back(1'b0);
        run_cmd(1'b0, 7'd0, 64'hFF, 1, 0);

        // Load vl=8 with bus error on element 2
        err_elem = 2;
        push_req(32'h100, 1'b0, 6'd0); push_req(32'h108, 1'b0, 6'd1);
        push_req(32'h110, 1'b0, 6'd2);
        exp_wb.push_back(6'd0); exp_wb.push_back(6'd1);
        exp_done.push_back(1'b1);
        run_cmd(1'b0, 7'd8, 64'hFF, 10, 0);
        err_elem = -1;

        // Next accept clears err
        exp_done.push_back(1'b0);
        run_cmd(1'b0, 7'd0, 64'h0, 1, 0);

        // Ack delayed 5 cycles, cmd_valid offered while busy
        ack_delay = 5;
        push_req(32'h100, 1'b0, 6'd0); push_req(32'h108, 1'b0, 6'd1);
        exp_wb.push_back(6'd0); exp_wb.push_back(6'd1);
        exp_done.push_back(1'b0);
        run_cmd(1'b0, 7'd2, 64'h3, 17, 1);

        // Reset asserted while a request is outstanding
        ack_delay = 20;
        push_req(32'h100, 1'b0, 6'd0);
        @(negedge clk); #3;
        cmd_valid = 1'b1; cmd_store = 1'b0; cmd_vl = 7'd4; cmd_mask = 64'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_vl = '0; cmd_mask = '0;
        begin
            bit got_req = 0;
            for (int t = 0; t < 20 && !got_req; t++) begin
                @(negedge clk); #3;
                if (mem_req) got_req = 1;
            end
            chk("req_before_reset", 64'(got_req), 64'd1);
        end
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_req.delete(); exp_wb.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("postrst");

        // vl=64, all elements enabled
        for (int i = 0; i < 64; i++) begin
            push_req(32'h100 + 32'(i) * 32'd8, 1'b0, 6'(i));
            exp_wb.push_back(6'(i));
        end
        exp_done.push_back(1'b0);
        run_cmd(1'b0, 7'd64, '1, 193, 0);

        repeat (3) @(negedge clk);
        chk("leftover_req", 64'(exp_req.size()), 64'd0);
        chk("leftover_wb", 64'(exp_wb.size()), 64'd0);
        chk("leftover_done", 64'(exp_done.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
